// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM states, cause codes,
// default vector locations and the memory-address helper.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_WAIT,
    ST_READ,
    ST_JUMP,
    ST_RETURN
  } exc_state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV  = 2'b11;

  localparam logic [7:0] DEF_OPC_VEC = 8'd253;
  localparam logic [7:0] DEF_OVF_VEC = 8'd254;
  localparam logic [7:0] DEF_DIV_VEC = 8'd255;

  localparam int unsigned DEF_MEM_WAIT = 1;

  function automatic logic [31:0] vec_addr(input logic [7:0] vec);
    return {24'b0, vec};
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder for exception requests: opcode > overflow > divzero.
// The divzero request only counts when EXC_DIVZERO_EN is defined.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter logic [7:0] OPC_VEC = DEF_OPC_VEC,
  parameter logic [7:0] OVF_VEC = DEF_OVF_VEC,
  parameter logic [7:0] DIV_VEC = DEF_DIV_VEC
) (
  input  logic       opc,
  input  logic       ovf,
  input  logic       div,
  output logic       valid,
  output logic [1:0] cause,
  output logic [7:0] vec
);

  logic div_req;

`ifdef EXC_DIVZERO_EN
  assign div_req = div;
`else
  assign div_req = 1'b0;
`endif

  always_comb begin
    valid = 1'b0;
    cause = CAUSE_NONE;
    if (opc) begin
      valid = 1'b1;
      cause = CAUSE_OPC;
    end else if (ovf) begin
      valid = 1'b1;
      cause = CAUSE_OVF;
    end else if (div_req) begin
      valid = 1'b1;
      cause = CAUSE_DIV;
    end
  end

  // vec is only consumed when valid is set, so the mux needs no build switch
  always_comb begin
    vec = '0;
    if (opc)      vec = OPC_VEC;
    else if (ovf) vec = OVF_VEC;
    else if (div) vec = DIV_VEC;
  end

endmodule

// File: rtl/exception_ctrl.sv
// Multicycle exception sequencer: saves EPC/cause, fetches the handler byte from a
// vector location, loads it into PC, and sequences eret. Optional macro: EXC_DIVZERO_EN.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter logic [7:0]  OPC_VEC  = DEF_OPC_VEC,
  parameter logic [7:0]  OVF_VEC  = DEF_OVF_VEC,
  parameter logic [7:0]  DIV_VEC  = DEF_DIV_VEC,
  parameter int unsigned MEM_WAIT = DEF_MEM_WAIT
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic        eret,
  input  logic [31:0] pc,
  input  logic [31:0] mem_data,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        pc_load,
  output logic [31:0] new_pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [7:0]  exc_count
);

  localparam logic [1:0] WAIT_LOAD = (MEM_WAIT == 0) ? 2'd0 : 2'(MEM_WAIT - 1);

  exc_state_t state, next_state;
  logic [1:0] wait_cnt;
  logic [7:0] handler;
  logic [7:0] vec_q;

  logic       req_valid;
  logic [1:0] req_cause;
  logic [7:0] req_vec;

  logic [23:0] mem_hi_unused;
  assign mem_hi_unused = mem_data[31:8];

  exc_prio_enc #(
    .OPC_VEC (OPC_VEC),
    .OVF_VEC (OVF_VEC),
    .DIV_VEC (DIV_VEC)
  ) u_prio (
    .opc   (exc_opcode),
    .ovf   (exc_overflow),
    .div   (exc_divzero),
    .valid (req_valid),
    .cause (req_cause),
    .vec   (req_vec)
  );

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      handler   <= '0;
      vec_q     <= '0;
      epc       <= '0;
      cause     <= CAUSE_NONE;
      exc_count <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            epc   <= pc - 32'd4;
            cause <= req_cause;
            vec_q <= req_vec;
            if (exc_count != '1) exc_count <= exc_count + 8'd1;
          end
        end
        ST_SAVE:   wait_cnt <= WAIT_LOAD;
        ST_WAIT:   wait_cnt <= wait_cnt - 2'd1;
        ST_READ:   handler  <= mem_data[7:0];
        ST_RETURN: cause    <= CAUSE_NONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    pc_load    = 1'b0;
    new_pc     = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid)  next_state = ST_SAVE;
        else if (eret)  next_state = ST_RETURN;
      end
      ST_SAVE, ST_WAIT, ST_READ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = vec_addr(vec_q);
        if (state == ST_SAVE)
          next_state = (MEM_WAIT == 0) ? ST_READ : ST_WAIT;
        else if (state == ST_WAIT)
          next_state = (wait_cnt == 2'd0) ? ST_READ : ST_WAIT;
        else
          next_state = ST_JUMP;
      end
      ST_JUMP: begin
        busy       = 1'b1;
        pc_load    = 1'b1;
        new_pc     = {24'b0, handler};
        next_state = ST_IDLE;
      end
      ST_RETURN: begin
        busy       = 1'b1;
        pc_load    = 1'b1;
        new_pc     = epc;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: three instances (MEM_WAIT 1, 0, 3) on shared stimulus,
// checked every cycle against a sequence-timing model plus directed literal checks.
module tb_exception_ctrl;

`ifdef EXC_DIVZERO_EN
  localparam bit DIVEN = 1'b1;
`else
  localparam bit DIVEN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        reset, exc_opcode, exc_overflow, exc_divzero, eret;
  logic [31:0] pc;

  logic        busy_v    [3];
  logic        mem_req_v [3];
  logic        pc_load_v [3];
  logic [31:0] mem_addr_v[3];
  logic [31:0] new_pc_v  [3];
  logic [31:0] epc_v     [3];
  logic [1:0]  cause_v   [3];
  logic [7:0]  cnt_v     [3];
  logic [31:0] mem_data_v[3];

  logic [7:0]  mem [256];
  int unsigned mw  [3] = '{1, 0, 3};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_rd(input logic req, input logic [31:0] a);
    return req ? {24'h5A5A5A, mem[a[7:0]]} : 32'hDEADBEEF;
  endfunction

  assign mem_data_v[0] = mem_rd(mem_req_v[0], mem_addr_v[0]);
  assign mem_data_v[1] = mem_rd(mem_req_v[1], mem_addr_v[1]);
  assign mem_data_v[2] = mem_rd(mem_req_v[2], mem_addr_v[2]);

  exception_ctrl #(.MEM_WAIT(1)) u_w1 (
    .Clk(Clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .eret(eret), .pc(pc), .mem_data(mem_data_v[0]),
    .busy(busy_v[0]), .mem_req(mem_req_v[0]), .mem_addr(mem_addr_v[0]),
    .pc_load(pc_load_v[0]), .new_pc(new_pc_v[0]), .epc(epc_v[0]),
    .cause(cause_v[0]), .exc_count(cnt_v[0]));

  exception_ctrl #(.MEM_WAIT(0)) u_w0 (
    .Clk(Clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .eret(eret), .pc(pc), .mem_data(mem_data_v[1]),
    .busy(busy_v[1]), .mem_req(mem_req_v[1]), .mem_addr(mem_addr_v[1]),
    .pc_load(pc_load_v[1]), .new_pc(new_pc_v[1]), .epc(epc_v[1]),
    .cause(cause_v[1]), .exc_count(cnt_v[1]));

  exception_ctrl #(.MEM_WAIT(3)) u_w3 (
    .Clk(Clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
    .exc_divzero(exc_divzero), .eret(eret), .pc(pc), .mem_data(mem_data_v[2]),
    .busy(busy_v[2]), .mem_req(mem_req_v[2]), .mem_addr(mem_addr_v[2]),
    .pc_load(pc_load_v[2]), .new_pc(new_pc_v[2]), .epc(epc_v[2]),
    .cause(cause_v[2]), .exc_count(cnt_v[2]));

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h expected=%h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Model: phase counts cycles into the current sequence (0 = not busy)
  int          m_phase[3];
  bit          m_ret  [3];
  logic [7:0]  m_vec  [3];
  logic [31:0] m_epc  [3];
  logic [1:0]  m_cause[3];
  int          m_cnt  [3];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[253] = 8'h21;
    mem[254] = 8'h80;
    mem[255] = 8'hC4;
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0; m_ret[i] = 1'b0; m_vec[i] = '0;
      m_epc[i] = '0; m_cause[i] = '0; m_cnt[i] = 0;
    end
  end

  always @(posedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        m_phase[i] <= 0; m_ret[i] <= 1'b0; m_epc[i] <= '0;
        m_cause[i] <= 2'd0; m_cnt[i] <= 0;
      end else if (m_phase[i] == 0) begin
        if (exc_opcode || exc_overflow || (DIVEN && exc_divzero)) begin
          m_phase[i] <= 1;
          m_ret[i]   <= 1'b0;
          m_epc[i]   <= pc - 32'd4;
          m_cnt[i]   <= (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
          if (exc_opcode) begin
            m_cause[i] <= 2'd1; m_vec[i] <= 8'd253;
          end else if (exc_overflow) begin
            m_cause[i] <= 2'd2; m_vec[i] <= 8'd254;
          end else begin
            m_cause[i] <= 2'd3; m_vec[i] <= 8'd255;
          end
        end else if (eret) begin
          m_phase[i] <= 1;
          m_ret[i]   <= 1'b1;
        end
      end else if (m_ret[i]) begin
        m_phase[i] <= 0;
        m_ret[i]   <= 1'b0;
        m_cause[i] <= 2'd0;
      end else begin
        m_phase[i] <= (m_phase[i] == 3 + int'(mw[i])) ? 0 : m_phase[i] + 1;
      end
    end
  end

  int          e_len;
  logic        e_req, e_load;
  logic [31:0] e_npc;

  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        e_len  = 3 + int'(mw[i]);
        e_req  = !m_ret[i] && m_phase[i] >= 1 && m_phase[i] < e_len;
        e_load = (!m_ret[i] && m_phase[i] == e_len) || (m_ret[i] && m_phase[i] == 1);
        if (!m_ret[i] && m_phase[i] == e_len) e_npc = {24'b0, mem[m_vec[i]]};
        else if (m_ret[i] && m_phase[i] == 1) e_npc = m_epc[i];
        else                                  e_npc = '0;
        check("busy",     i, {31'b0, busy_v[i]},    {31'b0, (m_phase[i] != 0)});
        check("mem_req",  i, {31'b0, mem_req_v[i]}, {31'b0, e_req});
        check("mem_addr", i, mem_addr_v[i],         e_req ? {24'b0, m_vec[i]} : 32'b0);
        check("pc_load",  i, {31'b0, pc_load_v[i]}, {31'b0, e_load});
        check("new_pc",   i, new_pc_v[i],           e_npc);
        check("epc",      i, epc_v[i],              m_epc[i]);
        check("cause",    i, {30'b0, cause_v[i]},   {30'b0, m_cause[i]});
        check("exc_count", i, {24'b0, cnt_v[i]},    32'(m_cnt[i]));
      end
    end
  end

  task automatic cyc();
    @(negedge Clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      if (!busy_v[0] && !busy_v[1] && !busy_v[2]) break;
      cyc();
    end
    check("idle_timeout", 0, {29'b0, busy_v[2], busy_v[1], busy_v[0]}, 32'b0);
  endtask

  int blen[3];
  int plen[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; exc_opcode = 1'b0; exc_overflow = 1'b0; exc_divzero = 1'b0;
    eret = 1'b0; pc = '0;
    chk_en = 1'b1;
    cyc();
    check("rst_busy", 0, {31'b0, busy_v[0]}, 32'b0);
    check("rst_cnt",  0, {24'b0, cnt_v[0]},  32'b0);
    reset = 1'b1;
    cyc();

    // Overflow at pc=0x40, handler byte 0x80 at 254
    pc = 32'h40; exc_overflow = 1'b1; cyc(); exc_overflow = 1'b0;
    check("ovf_addr_save", 0, mem_addr_v[0], 32'd254);
    check("ovf_epc",       0, epc_v[0], 32'h3C);
    check("ovf_cause",     0, {30'b0, cause_v[0]}, 32'd2);
    check("ovf_cnt",       0, {24'b0, cnt_v[0]}, 32'd1);
    cyc(); check("ovf_addr_wait", 0, mem_addr_v[0], 32'd254);
    cyc(); check("ovf_addr_read", 0, mem_addr_v[0], 32'd254);
    cyc();
    check("ovf_pc_load", 0, {31'b0, pc_load_v[0]}, 32'd1);
    check("ovf_new_pc",  0, new_pc_v[0], 32'h80);
    check("ovf_busy4",   0, {31'b0, busy_v[0]}, 32'd1);
    cyc(); check("ovf_busy_end", 0, {31'b0, busy_v[0]}, 32'd0);
    wait_idle();

    // eret back to EPC
    eret = 1'b1; cyc(); eret = 1'b0;
    check("eret_load",   0, {31'b0, pc_load_v[0]}, 32'd1);
    check("eret_new_pc", 0, new_pc_v[0], 32'h3C);
    cyc();
    check("eret_cause", 0, {30'b0, cause_v[0]}, 32'd0);
    check("eret_epc",   0, epc_v[0], 32'h3C);

    // Simultaneous opcode + overflow
    pc = 32'h100; exc_opcode = 1'b1; exc_overflow = 1'b1; cyc();
    exc_opcode = 1'b0; exc_overflow = 1'b0;
    check("prio_cause", 0, {30'b0, cause_v[0]}, 32'd1);
    check("prio_addr",  0, mem_addr_v[0], 32'd253);
    wait_idle();

    // Pulses during WAIT are dropped
    pc = 32'h200; exc_overflow = 1'b1; cyc(); exc_overflow = 1'b0;
    cyc();
    exc_opcode = 1'b1; eret = 1'b1; cyc(); exc_opcode = 1'b0; eret = 1'b0;
    wait_idle();
    check("drop_cause", 0, {30'b0, cause_v[0]}, 32'd2);
    check("drop_cnt",   0, {24'b0, cnt_v[0]}, 32'd3);

    // eret together with an exception: exception wins
    pc = 32'h300; eret = 1'b1; exc_opcode = 1'b1; cyc(); eret = 1'b0; exc_opcode = 1'b0;
    check("eret_exc_req",  0, {31'b0, mem_req_v[0]}, 32'd1);
    check("eret_exc_load", 0, {31'b0, pc_load_v[0]}, 32'd0);
    check("eret_exc_cnt",  0, {24'b0, cnt_v[0]}, 32'd4);
    wait_idle();

    // Reset during READ abandons the sequence
    pc = 32'h400; exc_overflow = 1'b1; cyc(); exc_overflow = 1'b0;
    cyc(); cyc();
    check("mid_read_req", 0, {31'b0, mem_req_v[0]}, 32'd1);
    reset = 1'b0; cyc(); reset = 1'b1;
    check("mid_rst_busy", 0, {31'b0, busy_v[0]}, 32'd0);
    check("mid_rst_load", 0, {31'b0, pc_load_v[0]}, 32'd0);
    check("mid_rst_addr", 0, mem_addr_v[0], 32'd0);
    check("mid_rst_epc",  0, epc_v[0], 32'd0);
    check("mid_rst_cnt",  0, {24'b0, cnt_v[0]}, 32'd0);
    check("mid_rst_busy3", 2, {31'b0, busy_v[2]}, 32'd0);
    cyc();

    // busy / pc_load lengths for MEM_WAIT 1, 0, 3
    pc = 32'h500; exc_overflow = 1'b1; cyc(); exc_overflow = 1'b0;
    for (int i = 0; i < 3; i++) begin blen[i] = 0; plen[i] = 0; end
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 3; i++) begin
        blen[i] += int'(busy_v[i]);
        plen[i] += int'(pc_load_v[i]);
      end
      if (!busy_v[0] && !busy_v[1] && !busy_v[2]) break;
      cyc();
    end
    check("busy_len_w1", 0, 32'(blen[0]), 32'd4);
    check("busy_len_w0", 1, 32'(blen[1]), 32'd3);
    check("busy_len_w3", 2, 32'(blen[2]), 32'd6);
    check("load_cnt_w0", 1, 32'(plen[1]), 32'd1);
    check("load_cnt_w3", 2, 32'(plen[2]), 32'd1);

    // pc=0 wraps EPC
    pc = 32'h0; exc_opcode = 1'b1; cyc(); exc_opcode = 1'b0;
    check("epc_wrap", 0, epc_v[0], 32'hFFFF_FFFC);
    wait_idle();

    // Divide by zero alone
    pc = 32'h600; exc_divzero = 1'b1; cyc(); exc_divzero = 1'b0;
`ifdef EXC_DIVZERO_EN
    check("div_cause", 0, {30'b0, cause_v[0]}, 32'd3);
    check("div_addr",  0, mem_addr_v[0], 32'd255);
`else
    check("div_ignored", 0, {31'b0, busy_v[0]}, 32'd0);
`endif
    wait_idle();

    // Back-to-back sequences, pushing the counter into saturation
    for (int n = 0; n < 260; n++) begin
      pc = 32'h1000 + 32'(n * 4);
      exc_overflow = 1'b1; cyc(); exc_overflow = 1'b0;
      wait_idle();
    end
    check("sat_cnt_w1", 0, {24'b0, cnt_v[0]}, 32'd255);
    check("sat_cnt_w3", 2, {24'b0, cnt_v[2]}, 32'd255);

    cyc();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Multicycle exception sequencer for the MIPS core. On an exception pulse it saves the faulting PC into EPC and records the cause. It then takes over the memory address path to fetch a one-byte handler address from a fixed vector location and loads that address into PC. While it works, it holds the main Control FSM with `busy`. It also sequences the return-from-exception jump back to EPC.

## Interface
Parameters:
- OPC_VEC, 8'd253, byte address of the handler address for an invalid opcode
- OVF_VEC, 8'd254, byte address of the handler address for an arithmetic overflow
- DIV_VEC, 8'd255, byte address of the handler address for a divide by zero
- MEM_WAIT, 1, wait cycles between address issue and data capture (legal range 0..3)

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low; reset=0 at a rising edge resets the block
- exc_opcode  in  1  one-cycle pulse from Control: undefined opcode decoded
- exc_overflow  in  1  one-cycle pulse from Control: ALU_overflow on a signed arithmetic op
- exc_divzero  in  1  one-cycle pulse: divide with a zero divisor
- eret  in  1  one-cycle pulse: return-from-exception decoded
- pc  in  32  current PC, already advanced by 4
- mem_data  in  32  memory Dataout
- busy  out  1  sequence in progress; Control stalls while high
- mem_req  out  1  overrides the IorD mux; memory address comes from `mem_addr`
- mem_addr  out  32  {24'b0, vector byte}
- pc_load  out  1  one-cycle PC write strobe
- new_pc  out  32  PC value to load when `pc_load`=1
- epc  out  32  exception program counter
- cause  out  2  cause code: 00 none, 01 opcode, 10 overflow, 11 divzero
- exc_count  out  8  count of exceptions taken, saturating at 255

## Operation
- States: IDLE, SAVE, WAIT, READ, JUMP, RETURN.
- IDLE, on any exception pulse: go to SAVE.
  - If several causes pulse together, priority is opcode > overflow > divzero.
  - epc <= pc - 32'd4, computed modulo 2^32 (pc=0 gives 32'hFFFFFFFC).
  - cause <= winning code.
  - exc_count <= exc_count+1, saturating at 255.
- IDLE, on eret with no exception pulse: go to RETURN.
  - If eret and an exception pulse arrive together, the exception wins and eret is dropped.
- SAVE: busy=1, mem_req=1, mem_addr = vector for the latched cause.
  - Next state is WAIT when MEM_WAIT>0, otherwise READ.
- WAIT: stays for exactly MEM_WAIT cycles, counted by a 2-bit down-counter, then goes to READ. Outputs are the same as in SAVE.
- READ: outputs are the same as in SAVE. mem_data[7:0] is captured into a handler register at the end of the cycle. Next state is JUMP.
- JUMP: pc_load=1, new_pc = {24'b0, handler}, mem_req=0, busy=1. Next state is IDLE.
- RETURN: pc_load=1, new_pc = epc, busy=1. cause <= 00 at the end of the cycle. Next state is IDLE. epc itself is unchanged.
- Exception or eret pulses arriving while not in IDLE are ignored and not queued.
- Reset values: busy=0, mem_req=0, mem_addr=0, pc_load=0, new_pc=0, epc=0, cause=00, exc_count=0, state=IDLE.

## Timing
- All outputs are registered or decoded from the registered state; there is no combinational path from input to output.
- Exception pulse sampled at edge E0 → SAVE during the cycle after E0.
- busy stays high for 3+MEM_WAIT cycles; with the default MEM_WAIT=1 that is 4 cycles. pc_load pulses in the last of these cycles.
- mem_data must be valid during READ, which begins 1+MEM_WAIT cycles after mem_addr is first driven.
- eret sampled at E0 → RETURN lasts 1 cycle, with busy=1 and pc_load=1 in that cycle.
- busy falls in the cycle after JUMP or RETURN. A pulse sampled in that first IDLE cycle is accepted.
- reset=0 at any edge, including mid-sequence: the block is in IDLE with reset values from the next cycle. An in-flight sequence is abandoned without a pc_load.

## Configuration
- EXC_DIVZERO_EN defined: the divide-by-zero cause is active, using DIV_VEC and cause 11.
- EXC_DIVZERO_EN undefined:
  - The exc_divzero port remains but is ignored.
  - Cause 11 is never produced.
  - DIV_VEC is unused.

## Structure
- Package exc_pkg holds:
  - the state enum;
  - the cause codes (CAUSE_NONE, CAUSE_OPC, CAUSE_OVF, CAUSE_DIV);
  - the default vector constants.
- Sub-module exc_prio_enc: combinational priority encoder mapping the three request pulses to a valid bit, a cause code and a vector byte. It honours EXC_DIVZERO_EN.

## Test plan
- Overflow with pc=32'h00000040, mem byte at 254 = 8'h80 → epc=32'h3C, cause=10, mem_addr=254 for 3 cycles, then pc_load=1 with new_pc=32'h80; busy high for 4 cycles; exc_count=1.
- exc_opcode and exc_overflow in the same cycle → cause=01, mem_addr=253.
- eret after the overflow case → one cycle with pc_load=1 and new_pc=32'h3C; then cause=00; epc still 32'h3C.
- Exception pulse during WAIT, and eret together with an exception → only the first or winning sequence runs; exc_count increments once.
- reset=0 during READ → next cycle all outputs are at reset values and no pc_load occurs. With MEM_WAIT=0 and 3 set, busy lasts 3 and 6 cycles respectively.
- With EXC_DIVZERO_EN undefined, exc_divzero=1 → busy stays 0. With the macro defined → cause=11, mem_addr=255.
